// File: rtl/mips_fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_fetch_pkg
//  Description : Shared constants for the instruction-fetch stage:
//                next-PC select encodings, the bubble instruction word and
//                the default reset PC.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_fetch_pkg;

    // Next-PC select encodings driven by the control/hazard logic
    localparam logic [1:0] PC_SRC_SEQ = 2'b00;
    localparam logic [1:0] PC_SRC_BR  = 2'b01;
    localparam logic [1:0] PC_SRC_J   = 2'b10;
    localparam logic [1:0] PC_SRC_JR  = 2'b11;

    // sll $0,$0,0 - the canonical MIPS no-op used as a pipeline bubble
    localparam logic [31:0] C_NOP_INSTR = 32'h0000_0000;

    // Default PC after reset; must be word aligned
    localparam logic [31:0] C_RESET_PC  = 32'h0000_0000;

endpackage : mips_fetch_pkg
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// ============================================================================
//  Module      : if_id_reg
//  Description : IF/ID pipeline register. Flush inserts a bubble and has
//                priority over stall; stall holds every field.
//                Optional macro FETCH_ALIGN_CHECK_EN adds a misalign field.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_id_reg
    import mips_fetch_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = C_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_flush,
    input  logic        i_stall,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc_plus4,
`ifdef FETCH_ALIGN_CHECK_EN
    input  logic        i_misalign,
    output logic        o_misalign,
`endif
    output logic [31:0] o_instr,
    output logic [31:0] o_pc_plus4,
    output logic        o_valid
);

    logic [31:0] r_instr;
    logic [31:0] r_pc_plus4;
    logic        r_valid;

    // Capture the fetched word; flush beats stall, stall holds everything
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instr    <= NOP_INSTR;
            r_pc_plus4 <= 32'd0;
            r_valid    <= 1'b0;
        end else if (i_flush) begin
            r_instr    <= NOP_INSTR;
            r_pc_plus4 <= 32'd0;
            r_valid    <= 1'b0;
        end else if (!i_stall) begin
            r_instr    <= i_instr;
            r_pc_plus4 <= i_pc_plus4;
            r_valid    <= 1'b1;
        end
    end

    assign o_instr    = r_instr;
    assign o_pc_plus4 = r_pc_plus4;
    assign o_valid    = r_valid;

`ifdef FETCH_ALIGN_CHECK_EN
    logic r_misalign;

    // Misalign flag follows the same flush/stall priority as the instruction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_misalign <= 1'b0;
        end else if (i_flush) begin
            r_misalign <= 1'b0;
        end else if (!i_stall) begin
            r_misalign <= i_misalign;
        end
    end

    assign o_misalign = r_misalign;
`endif

endmodule : if_id_reg
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage
//  Description : Instruction-fetch stage. Holds the PC, selects the next PC
//                (sequential / branch / jump / jump-register), drives the
//                instruction memory address and loads the IF/ID register.
//                Optional macro FETCH_ALIGN_CHECK_EN: clears target bits
//                [1:0] and reports the event on misalign_d.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
    import mips_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = C_RESET_PC,
    parameter logic [31:0] NOP_INSTR = C_NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_f,
    input  logic        flush_d,
    input  logic [1:0]  pc_src,
    input  logic [31:0] branch_target,
    input  logic [31:0] jump_target,
    input  logic [31:0] jr_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rd,
    output logic [31:0] pc_f,
    output logic [31:0] instr_d,
    output logic [31:0] pc_plus4_d,
`ifdef FETCH_ALIGN_CHECK_EN
    output logic        misalign_d,
`endif
    output logic        valid_d
);

    logic [31:0] r_pc;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_target;
    logic        w_redirect;
    logic [31:0] w_pc_next;

    // Sequential successor wraps naturally modulo 2^32
    assign w_pc_plus4 = r_pc + 32'd4;

    // Select the redirect target requested by pc_src
    always_comb begin
        w_target   = branch_target;
        w_redirect = 1'b1;
        case (pc_src)
            PC_SRC_SEQ: begin
                w_target   = w_pc_plus4;
                w_redirect = 1'b0;
            end
            PC_SRC_BR:  w_target = branch_target;
            PC_SRC_J:   w_target = jump_target;
            PC_SRC_JR:  w_target = jr_target;
            default:    w_target = w_pc_plus4;
        endcase
    end

`ifdef FETCH_ALIGN_CHECK_EN
    logic w_misaligned;
    logic r_misalign_f;

    // A redirect to a non-word address is forced to the enclosing word
    assign w_misaligned = w_redirect && (w_target[1:0] != 2'b00);
    assign w_pc_next    = {w_target[31:2], 2'b00};

    // Flag stays with the PC it describes until the PC moves on
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_misalign_f <= 1'b0;
        end else if (!stall_f) begin
            r_misalign_f <= w_misaligned;
        end
    end
`else
    // Targets load unmodified; the instruction memory ignores bits [1:0]
    assign w_pc_next = w_target;
`endif

    // Program counter: holds on stall, otherwise advances to the next PC
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else if (!stall_f) begin
            r_pc <= w_pc_next;
        end
    end

    assign pc_f      = r_pc;
    assign imem_addr = r_pc;

    if_id_reg #(
        .NOP_INSTR  (NOP_INSTR)
    ) u_if_id_reg (
        .clk        (clk),
        .rst        (reset),
        .i_flush    (flush_d),
        .i_stall    (stall_f),
        .i_instr    (imem_rd),
        .i_pc_plus4 (w_pc_plus4),
`ifdef FETCH_ALIGN_CHECK_EN
        .i_misalign (r_misalign_f),
        .o_misalign (misalign_d),
`endif
        .o_instr    (instr_d),
        .o_pc_plus4 (pc_plus4_d),
        .o_valid    (valid_d)
    );

endmodule : fetch_stage
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_stage
//  Description : Directed self-checking bench for fetch_stage. The
//                instruction memory returns 32'h1000_0000 + address so every
//                fetched word identifies where it came from.
//                Honors FETCH_ALIGN_CHECK_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        stall_f;
    logic        flush_d;
    logic [1:0]  pc_src;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] jr_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_rd;
    logic [31:0] pc_f;
    logic [31:0] instr_d;
    logic [31:0] pc_plus4_d;
    logic        valid_d;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        misalign_d;
`endif

    int n_checks;
    int n_errors;

    fetch_stage u_dut (
        .clk           (clk),
        .reset         (reset),
        .stall_f       (stall_f),
        .flush_d       (flush_d),
        .pc_src        (pc_src),
        .branch_target (branch_target),
        .jump_target   (jump_target),
        .jr_target     (jr_target),
        .imem_addr     (imem_addr),
        .imem_rd       (imem_rd),
        .pc_f          (pc_f),
        .instr_d       (instr_d),
        .pc_plus4_d    (pc_plus4_d),
`ifdef FETCH_ALIGN_CHECK_EN
        .misalign_d    (misalign_d),
`endif
        .valid_d       (valid_d)
    );

    // Combinational instruction memory with address-tagged contents
    assign imem_rd = 32'h1000_0000 + imem_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Compare the whole visible fetch state against expected values
    task automatic chk_state(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                             input logic [31:0] pp4, input logic vld);
        chk({tag, ".pc"},    pc_f,       pc);
        chk({tag, ".addr"},  imem_addr,  pc);
        chk({tag, ".instr"}, instr_d,    ins);
        chk({tag, ".pp4"},   pc_plus4_d, pp4);
        chk({tag, ".valid"}, {31'd0, valid_d}, {31'd0, vld});
    endtask

    // Advance one clock and settle away from the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        reset         = 1'b1;
        stall_f       = 1'b0;
        flush_d       = 1'b0;
        pc_src        = 2'b00;
        branch_target = 32'd0;
        jump_target   = 32'd0;
        jr_target     = 32'd0;

        // Reset state before any clock edge
        #3;
        chk_state("rst0", 32'h0, 32'h0, 32'h0, 1'b0);
        tick();
        tick();
        chk_state("rst_hold", 32'h0, 32'h0, 32'h0, 1'b0);

        // Release: sequential fetch 0,4,8,C with instr_d lagging one cycle
        reset = 1'b0;
        #1;
        chk_state("rel", 32'h0, 32'h0, 32'h0, 1'b0);
        tick(); chk_state("seq1", 32'h4, 32'h1000_0000, 32'h4, 1'b1);
        tick(); chk_state("seq2", 32'h8, 32'h1000_0004, 32'h8, 1'b1);
        tick(); chk_state("seq3", 32'hC, 32'h1000_0008, 32'hC, 1'b1);

        // Taken branch with flush: old fetch squashed, target fetched next
        pc_src = 2'b01; branch_target = 32'h40; flush_d = 1'b1;
        tick(); chk_state("br_flush", 32'h40, 32'h0, 32'h0, 1'b0);
        pc_src = 2'b00; flush_d = 1'b0;
        tick(); chk_state("br_tgt", 32'h44, 32'h1000_0040, 32'h44, 1'b1);

        // Branch without flush to reach PC=0x10
        pc_src = 2'b01; branch_target = 32'h10;
        tick(); chk_state("br_nf", 32'h10, 32'h1000_0044, 32'h48, 1'b1);

        // Stall three cycles with a pending jump: everything holds
        stall_f = 1'b1; pc_src = 2'b10; jump_target = 32'h80;
        for (int i = 0; i < 3; i++) begin
            tick(); chk_state("stall", 32'h10, 32'h1000_0044, 32'h48, 1'b1);
        end
        stall_f = 1'b0;
        tick(); chk_state("jmp", 32'h80, 32'h1000_0010, 32'h14, 1'b1);
        pc_src = 2'b00;

        // Stall and flush together: PC holds, IF/ID becomes a bubble
        stall_f = 1'b1; flush_d = 1'b1;
        tick(); chk_state("stl_fl", 32'h80, 32'h0, 32'h0, 1'b0);
        stall_f = 1'b0; flush_d = 1'b0;
        tick(); chk_state("after_sf", 32'h84, 32'h1000_0080, 32'h84, 1'b1);

        // jr to the top word, then sequential wrap to zero
        pc_src = 2'b11; jr_target = 32'hFFFF_FFFC;
        tick(); chk_state("jr_top", 32'hFFFF_FFFC, 32'h1000_0084, 32'h88, 1'b1);
        pc_src = 2'b00;
        tick(); chk_state("wrap", 32'h0, 32'h0FFF_FFFC, 32'h0, 1'b1);

        // jr to a non-word address
        pc_src = 2'b11; jr_target = 32'h46;
`ifdef FETCH_ALIGN_CHECK_EN
        tick(); chk_state("jr_mis", 32'h44, 32'h1000_0000, 32'h4, 1'b1);
        chk("jr_mis.flag_pre", {31'd0, misalign_d}, 32'd0);
        pc_src = 2'b00;
        tick(); chk_state("mis_d", 32'h48, 32'h1000_0044, 32'h48, 1'b1);
        chk("mis_d.flag", {31'd0, misalign_d}, 32'd1);
        tick(); chk("mis_clr.flag", {31'd0, misalign_d}, 32'd0);
        chk("mis_clr.pc", pc_f, 32'h4C);
`else
        tick(); chk_state("jr_odd", 32'h46, 32'h1000_0000, 32'h4, 1'b1);
        pc_src = 2'b00;
        tick(); chk_state("odd_seq", 32'h4A, 32'h1000_0046, 32'h4A, 1'b1);
`endif

        // Asynchronous reset mid-stream: clears state without a clock edge
        #2;
        reset = 1'b1;
        #1;
        chk_state("arst", 32'h0, 32'h0, 32'h0, 1'b0);
`ifdef FETCH_ALIGN_CHECK_EN
        chk("arst.flag", {31'd0, misalign_d}, 32'd0);
`endif
        tick();
        reset = 1'b0;
        tick(); chk_state("post_rst", 32'h4, 32'h1000_0000, 32'h4, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_fetch_stage
`default_nettype wire
